word_scanner: RTL and testbench

- Upstream stage of the dictionary lookup path.
- Consumes the input character stream one character per handshake and skips leading delimiters.
- Packs each whitespace-delimited word into a fixed, zero-padded key array, then strobes the key into the dictionary index finder.
- Holds the key stable until the consumer acknowledges, then scans the next word.

---
 rtl/forth_pkg.sv | 29 ++
 rtl/word_scanner_if.sv | 39 +++
 rtl/word_scanner_char_class.sv | 39 +++
 rtl/word_scanner.sv | 136 +++++++++++++
 tb/tb_word_scanner.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/forth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : forth_pkg
// Purpose  : Shared definitions for the dictionary lookup front end:
//            character-class threshold, word scanner state encoding and
//            the delimiter test used by every stage that tokenises input.
// Revision : 1.0 - initial release
// ============================================================================
package forth_pkg;

    // Every character at or below this code point separates words.
    localparam logic [7:0] CHAR_DELIM_MAX = 8'h20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        PUBLISH = 3'd2,
        STROBE  = 3'd3,
        HOLD    = 3'd4
    } scan_state_t;

    // Characters are zero-extended to 32 bits by the caller so the same
    // test serves any character width up to 32.
    function automatic logic is_delim(input logic [31:0] c);
        return (c <= {24'h000000, CHAR_DELIM_MAX});
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : word_scanner_if
// Purpose  : Character-in / key-out bundle of the word scanner.
// Ports    : i_char, i_char_valid, o_char_ready  - character stream handshake
//            o_key, o_len, o_overflow            - published word
//            o_update, i_ack, o_busy             - lookup strobe and release
//            Modport master is the scanner side, slave the environment
//            (character source plus dictionary index finder).
// Revision : 1.0 - initial release
// ============================================================================
interface word_scanner_if #(
    parameter int KEY_WIDTH  = 8,
    parameter int KEY_LENGTH = 4
);
    localparam int LEN_BITS = $clog2(KEY_LENGTH + 1);

    logic [KEY_WIDTH-1:0]                  i_char;
    logic                                  i_char_valid;
    logic                                  o_char_ready;
    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0]  o_key;
    logic [LEN_BITS-1:0]                   o_len;
    logic                                  o_overflow;
    logic                                  o_update;
    logic                                  i_ack;
    logic                                  o_busy;

    modport master (
        input  i_char, i_char_valid, i_ack,
        output o_char_ready, o_key, o_len, o_overflow, o_update, o_busy
    );

    modport slave (
        output i_char, i_char_valid, i_ack,
        input  o_char_ready, o_key, o_len, o_overflow, o_update, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/word_scanner_char_class.sv
`default_nettype none
// ============================================================================
// Module   : char_class
// Purpose  : Combinational character classifier shared by the word scanner
//            and the number parser.
// Ports    : i_char     - character under test
//            o_is_delim - character is a word separator
//            o_folded   - character, upper-cased when FOLD_CASE is set
// Revision : 1.0 - initial release
// ============================================================================
module char_class
    import forth_pkg::*;
#(
    parameter int KEY_WIDTH = 8,
    parameter int FOLD_CASE = 0
) (
    input  wire logic [KEY_WIDTH-1:0] i_char,
    output logic                      o_is_delim,
    output logic [KEY_WIDTH-1:0]      o_folded
);

    logic [31:0] w_char_ext;

    assign w_char_ext = 32'(i_char);
    assign o_is_delim = is_delim(w_char_ext);

    generate
        if (FOLD_CASE != 0) begin : g_fold
            logic w_lower;
            assign w_lower  = (w_char_ext >= 32'h61) && (w_char_ext <= 32'h7A);
            // 'a'..'z' sit exactly 0x20 above 'A'..'Z'.
            assign o_folded = w_lower ? (i_char - KEY_WIDTH'(32)) : i_char;
        end else begin : g_no_fold
            assign o_folded = i_char;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/word_scanner.sv
`default_nettype none
// ============================================================================
// Module   : word_scanner
// Purpose  : Splits the incoming character stream into whitespace-delimited
//            words, packs each into a zero-padded key, strobes the dictionary
//            index finder and holds the key until it is acknowledged.
// Ports    : i_clk   - system clock
//            i_reset - asynchronous active-high reset
//            bus     - word_scanner_if.master (character handshake, key,
//                      length, overflow, update strobe, ack, busy)
// Revision : 1.0 - initial release
// ============================================================================
module word_scanner
    import forth_pkg::*;
#(
    parameter int KEY_WIDTH  = 8,
    parameter int KEY_LENGTH = 4,
    parameter int FOLD_CASE  = 0
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    word_scanner_if.master bus
);

    localparam int LEN_BITS = $clog2(KEY_LENGTH + 1);

    scan_state_t                          state_q, state_d;
    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] key_q, key_d;
    logic [LEN_BITS-1:0]                  len_q, len_d;
    logic                                 ovf_q, ovf_d;
    logic                                 upd_q, upd_d;

    logic                                 w_is_delim;
    logic [KEY_WIDTH-1:0]                 w_folded;
    logic                                 w_char_ready;
    logic                                 w_accept;

    char_class #(
        .KEY_WIDTH (KEY_WIDTH),
        .FOLD_CASE (FOLD_CASE)
    ) u_char_class (
        .i_char     (bus.i_char),
        .o_is_delim (w_is_delim),
        .o_folded   (w_folded)
    );

    // Ready drops with reset itself so nothing is taken while reset is high.
    assign w_char_ready = ((state_q == IDLE) || (state_q == COLLECT)) && !i_reset;
    assign w_accept     = bus.i_char_valid && w_char_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept && !w_is_delim) begin
                    state_d  = COLLECT;
                    key_d    = '0;
                    key_d[0] = w_folded;
                    len_d    = LEN_BITS'(1);
                    ovf_d    = 1'b0;
                end
            end

            COLLECT: begin
                if (w_accept) begin
                    if (w_is_delim) begin
                        state_d = PUBLISH;
                    end else if (len_q < LEN_BITS'(KEY_LENGTH)) begin
                        // Loop compare keeps the slot select in range even
                        // though len_q can encode KEY_LENGTH itself.
                        for (int i = 0; i < KEY_LENGTH; i++) begin
                            if (LEN_BITS'(i) == len_q) begin
                                key_d[i] = w_folded;
                            end
                        end
                        len_d = len_q + LEN_BITS'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end

            PUBLISH: begin
                // Key has been stable for a full cycle; raise the strobe
                // registered so it appears during STROBE.
                state_d = STROBE;
                upd_d   = 1'b1;
            end

            STROBE: begin
                state_d = HOLD;
            end

            HOLD: begin
                if (bus.i_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.o_char_ready = w_char_ready;
    assign bus.o_key        = key_q;
    assign bus.o_len        = len_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_update     = upd_q;
    assign bus.o_busy       = (state_q == PUBLISH) || (state_q == STROBE) ||
                              (state_q == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_word_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_scanner
// Purpose  : Self-checking bench for word_scanner. Two instances share the
//            stimulus: one without case folding, one with it. Expected keys
//            come from the word text itself (truncate, fold, zero-pad).
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_scanner;

    localparam int KW = 8;
    localparam int KL = 4;
    localparam int LB = $clog2(KL + 1);

    typedef logic [7:0] ch_t;
    typedef ch_t        cq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    word_scanner_if #(.KEY_WIDTH(KW), .KEY_LENGTH(KL)) bus0 ();
    word_scanner_if #(.KEY_WIDTH(KW), .KEY_LENGTH(KL)) bus1 ();

    word_scanner #(.KEY_WIDTH(KW), .KEY_LENGTH(KL), .FOLD_CASE(0)) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    word_scanner #(.KEY_WIDTH(KW), .KEY_LENGTH(KL), .FOLD_CASE(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    // ---------------- reference model ----------------
    function automatic cq_t to_q(input string s);
        cq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [KW*KL-1:0] exp_key(input cq_t w, input bit fold);
        logic [KW*KL-1:0] k;
        ch_t c;
        k = '0;
        for (int i = 0; i < w.size() && i < KL; i++) begin
            c = w[i];
            if (fold && c >= "a" && c <= "z") c = c - 8'h20;
            k[i*KW +: KW] = c;
        end
        return k;
    endfunction

    function automatic int exp_len(input cq_t w);
        return (w.size() > KL) ? KL : w.size();
    endfunction

    function automatic bit exp_ovf(input cq_t w);
        return w.size() > KL;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input ch_t c, input logic a);
        bus0.i_char_valid = v; bus0.i_char = c; bus0.i_ack = a;
        bus1.i_char_valid = v; bus1.i_char = c; bus1.i_ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " key0"},  64'(bus0.o_key), 64'd0);
        check({tag, " key1"},  64'(bus1.o_key), 64'd0);
        check({tag, " len0"},  64'(bus0.o_len), 64'd0);
        check({tag, " ovf0"},  64'(bus0.o_overflow), 64'd0);
        check({tag, " upd0"},  64'(bus0.o_update), 64'd0);
        check({tag, " upd1"},  64'(bus1.o_update), 64'd0);
        check({tag, " busy0"}, 64'(bus0.o_busy), 64'd0);
        check({tag, " rdy0"},  64'(bus0.o_char_ready), 64'd0);
    endtask

    task automatic check_key(input string tag, input cq_t w);
        check({tag, " key0"}, 64'(bus0.o_key), 64'(exp_key(w, 1'b0)));
        check({tag, " key1"}, 64'(bus1.o_key), 64'(exp_key(w, 1'b1)));
        check({tag, " len0"}, 64'(bus0.o_len), 64'(exp_len(w)));
        check({tag, " len1"}, 64'(bus1.o_len), 64'(exp_len(w)));
        check({tag, " ovf0"}, 64'(bus0.o_overflow), 64'(exp_ovf(w)));
        check({tag, " ovf1"}, 64'(bus1.o_overflow), 64'(exp_ovf(w)));
    endtask

    // Present a character and wait (bounded) for it to be taken.
    task automatic send_char(input ch_t c);
        int t;
        t = 0;
        drive(1'b1, c, 1'b0);
        while (bus0.o_char_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) check("ready timeout", 64'(bus0.o_char_ready), 64'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    // Entered #1 after the edge that accepted the terminating delimiter.
    task automatic publish_seq(input cq_t w, input int hold_cycles, input bit early_ack);
        check("pub upd0",  64'(bus0.o_update), 64'd0);
        check("pub busy0", 64'(bus0.o_busy), 64'd1);
        check("pub rdy0",  64'(bus0.o_char_ready), 64'd0);
        check_key("pub", w);
        drive(1'b0, 8'h00, early_ack);
        tick();
        check("strobe upd0", 64'(bus0.o_update), 64'd1);
        check("strobe upd1", 64'(bus1.o_update), 64'd1);
        check_key("strobe", w);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("hold upd0",  64'(bus0.o_update), 64'd0);
        check("hold busy0", 64'(bus0.o_busy), 64'd1);
        for (int i = 0; i < hold_cycles; i++) begin
            drive(1'b1, ch_t'($urandom_range(33, 126)), 1'b0);
            tick();
            check("hold busy0", 64'(bus0.o_busy), 64'd1);
            check("hold busy1", 64'(bus1.o_busy), 64'd1);
            check("hold rdy0",  64'(bus0.o_char_ready), 64'd0);
            check("hold upd0",  64'(bus0.o_update), 64'd0);
            check_key("hold", w);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("ack busy0", 64'(bus0.o_busy), 64'd0);
        check("ack busy1", 64'(bus1.o_busy), 64'd0);
        check("ack rdy0",  64'(bus0.o_char_ready), 64'd1);
        check("ack upd0",  64'(bus0.o_update), 64'd0);
        check_key("idle keep", w);
    endtask

    task automatic run_word(input cq_t lead, input cq_t w, input ch_t term,
                            input int hold_cycles, input bit early_ack);
        foreach (lead[i]) send_char(lead[i]);
        if (lead.size() > 0) check("lead idle busy0", 64'(bus0.o_busy), 64'd0);
        foreach (w[i]) send_char(w[i]);
        check("collect busy0", 64'(bus0.o_busy), 64'd0);
        check("collect upd0",  64'(bus0.o_update), 64'd0);
        send_char(term);
        publish_seq(w, hold_cycles, early_ack);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cq_t lead;
        cq_t w;
        int  nl;
        int  wl;

        drive(1'b0, 8'h00, 1'b0);
        #1;
        check_zero("reset");
        tick();
        tick();
        check_zero("reset held");
        rst = 1'b0;
        tick();
        check("post reset rdy0", 64'(bus0.o_char_ready), 64'd1);
        check("post reset busy0", 64'(bus0.o_busy), 64'd0);

        // Leading delimiters skipped, short word zero-padded.
        run_word(to_q("  "), to_q("DUP"), " ", 3, 1'b0);
        // Over-long word: truncated, overflow sticky.
        run_word(to_q(""), to_q("SWAPX"), " ", 0, 1'b0);
        // Next word clears the stale slots and overflow.
        run_word(to_q(""), to_q("OR"), " ", 0, 1'b0);
        // Exactly KEY_LENGTH chars, LF terminator.
        run_word(to_q(""), to_q("OVER"), 8'h0A, 0, 1'b0);
        // Lowercase word; ack raised during PUBLISH/STROBE must be ignored.
        run_word(to_q(""), to_q("dup"), " ", 4, 1'b1);

        // Delimiters only: never publishes.
        lead = to_q(" \t\n\r");
        lead.push_back(8'h00);
        lead.push_back(8'h20);
        foreach (lead[i]) begin
            send_char(lead[i]);
            check("delim only busy0", 64'(bus0.o_busy), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("delim only upd0", 64'(bus0.o_update), 64'd0);
        end

        // Reset mid-word.
        send_char("D");
        send_char("R");
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid-word reset");
        tick();
        tick();
        check_zero("mid-word reset held");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after reset upd0", 64'(bus0.o_update), 64'd0);
            check("after reset busy0", 64'(bus0.o_busy), 64'd0);
        end
        run_word(to_q(""), to_q("DROP"), " ", 1, 1'b0);

        // Long hold with characters offered throughout.
        run_word(to_q(""), to_q("HOLD"), " ", 20, 1'b0);

        // Randomised words, delimiters and hold lengths.
        for (int r = 0; r < 12; r++) begin
            lead.delete();
            w.delete();
            nl = $urandom_range(0, 2);
            wl = $urandom_range(1, 6);
            for (int i = 0; i < nl; i++) lead.push_back(ch_t'($urandom_range(0, 32)));
            for (int i = 0; i < wl; i++) w.push_back(ch_t'($urandom_range(33, 126)));
            run_word(lead, w, ch_t'($urandom_range(0, 32)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
